// File: rtl/mdu_e.sv
// ============================================================================
// Module      : mdu_e
// Description : E-stage multiply/divide unit owning HI/LO; fixed-latency
//               MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
//               Optional MADD/MADDU (op 6/7) when MDU_MADD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] c_OP_MADD  = 3'd6;
  localparam logic [2:0] c_OP_MADDU = 3'd7;
`endif
  localparam logic [4:0] c_MULT_LAT = 5'(MULT_CYCLES);
  localparam logic [4:0] c_DIV_LAT  = 5'(DIV_CYCLES);

  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_phi, r_plo;

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_udiv_b, w_quo_u, w_rem_u;
  logic [31:0] w_abs_a, w_abs_b, w_sdiv_b, w_quo_m, w_rem_m, w_quo_s, w_rem_s;
  logic        w_long, w_wr_hi, w_wr_lo;
  logic [4:0]  w_lat;
  logic [63:0] w_res;

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced to 1 on zero so the divider never sees x/0; the result is discarded then.
  assign w_udiv_b = (B == 32'd0) ? 32'd1 : B;
  assign w_quo_u  = A / w_udiv_b;
  assign w_rem_u  = A % w_udiv_b;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign w_abs_a  = A[31] ? -A : A;
  assign w_abs_b  = B[31] ? -B : B;
  assign w_sdiv_b = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_quo_m  = w_abs_a / w_sdiv_b;
  assign w_rem_m  = w_abs_a % w_sdiv_b;
  assign w_quo_s  = (A[31] ^ B[31]) ? -w_quo_m : w_quo_m;
  assign w_rem_s  = A[31] ? -w_rem_m : w_rem_m;

  always_comb begin
    w_long  = 1'b0;
    w_lat   = 5'd0;
    w_wr_hi = 1'b0;
    w_wr_lo = 1'b0;
    w_res   = {r_hi, r_lo};
    case (op)
      c_OP_MULT:  begin w_long = 1'b1; w_lat = c_MULT_LAT; w_res = w_prod_s; end
      c_OP_MULTU: begin w_long = 1'b1; w_lat = c_MULT_LAT; w_res = w_prod_u; end
      c_OP_DIV: begin
        w_long = 1'b1;
        w_lat  = c_DIV_LAT;
        if (B != 32'd0) w_res = {w_rem_s, w_quo_s};
      end
      c_OP_DIVU: begin
        w_long = 1'b1;
        w_lat  = c_DIV_LAT;
        if (B != 32'd0) w_res = {w_rem_u, w_quo_u};
      end
      c_OP_MTHI:  w_wr_hi = 1'b1;
      c_OP_MTLO:  w_wr_lo = 1'b1;
`ifdef MDU_MADD_EN
      c_OP_MADD:  begin w_long = 1'b1; w_lat = c_MULT_LAT; w_res = {r_hi, r_lo} + w_prod_s; end
      c_OP_MADDU: begin w_long = 1'b1; w_lat = c_MULT_LAT; w_res = {r_hi, r_lo} + w_prod_u; end
`endif
      default: ;
    endcase
  end

  // HI/LO cannot change while busy, so a zero-divisor pending copy of them commits as a no-op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 5'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
    end else if (r_cnt != 5'd0) begin
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (start) begin
      if (w_long) begin
        r_cnt <= w_lat;
        r_phi <= w_res[63:32];
        r_plo <= w_res[31:0];
      end
      if (w_wr_hi) r_hi <= A;
      if (w_wr_lo) r_lo <= A;
    end
  end

  assign busy = (r_cnt != 5'd0);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_e.sv
// ============================================================================
// Module      : tb_mdu_e
// Description : Self-checking bench for mdu_e against an arithmetic HI/LO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_e;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] m_hl    = 64'd0;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int latency(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return MC;
      3'd2, 3'd3: return DC;
`ifdef MDU_MADD_EN
      3'd6, 3'd7: return MC;
`endif
      default: return 0;
    endcase
  endfunction

  // Architectural result {hi,lo} after op o, from plain 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     qv, rv;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return hl;
        q = sa / sb; r = sa % sb; qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return hl;
        qv = ua / ub; rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
      3'd4: return {a, hl[31:0]};
      3'd5: return {hl[63:32], a};
`ifdef MDU_MADD_EN
      3'd6: return hl + 64'(sa * sb);
      3'd7: return hl + ua * ub;
`endif
      default: return hl;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat, cnt;
    logic [63:0] old;
    lat = latency(o);
    old = m_hl;
    op = o; A = a; B = b; start = 1'b1;
    tick;
    start = 1'b0;
    if (lat == 0) begin
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL %s busy: got %b want 0", name, busy);
      end
    end else begin
      n_tests++;
      if ({hi, lo} !== old) begin
        n_fail++; $display("FAIL %s hold: got %h want %h", name, {hi, lo}, old);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 64) begin
        cnt++;
        A = $urandom; B = $urandom;
        tick;
      end
      n_tests++;
      if (cnt != lat) begin
        n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, cnt, lat);
      end
    end
    n_tests++;
    if (hi !== eh) begin
      n_fail++; $display("FAIL %s hi: got %h want %h", name, hi, eh);
    end
    n_tests++;
    if (lo !== el) begin
      n_fail++; $display("FAIL %s lo: got %h want %h", name, lo, el);
    end
    m_hl = {eh, el};
  endtask

  task automatic run_model(input string name, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = model(o, a, b, m_hl);
    run_op(name, o, a, b, e[63:32], e[31:0]);
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (3) tick;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_tests++;
    if (hi !== 32'd0) begin n_fail++; $display("FAIL reset hi: got %h want 0", hi); end
    n_tests++;
    if (lo !== 32'd0) begin n_fail++; $display("FAIL reset lo: got %h want 0", lo); end
    m_hl = 64'd0;
    reset = 1'b1;
    run_op("rst_release_mtlo", 3'd5, 32'hABCD_1234, 32'd0, 32'd0, 32'hABCD_1234);
  endtask

  task automatic test_reset_mid;
    op = 3'd0; A = 32'd3; B = 32'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    n_tests++;
    if (hi !== 32'd0) begin n_fail++; $display("FAIL rst_mid hi: got %h want 0", hi); end
    n_tests++;
    if (lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid lo: got %h want 0", lo); end
    tick;
    reset = 1'b1;
    repeat (MC + 3) tick;
    n_tests++;
    if ({busy, hi, lo} !== 65'd0) begin
      n_fail++; $display("FAIL rst_mid late_commit: got %b %h %h want 0 0 0", busy, hi, lo);
    end
    m_hl = 64'd0;
  endtask

  task automatic test_mult;
    run_op("mult_neg",  3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    for (int i = 0; i < 6; i++) run_model("mult_rand", 3'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_div;
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] b;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 100)) - 32'd50 : $urandom;
      if (b == 32'd0) b = 32'd7;
      run_model("div_rand", 3'($urandom_range(2, 3)), $urandom, b);
    end
  endtask

  task automatic test_divzero_ignored;
    int cnt;
    run_op("mthi", 3'd4, 32'h11, 32'd0, 32'h11, m_hl[31:0]);
    run_op("mtlo", 3'd5, 32'h22, 32'd0, 32'h11, 32'h22);
    op = 3'd3; A = $urandom; B = 32'd0; start = 1'b1;
    tick;
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      if (cnt == 3) begin op = 3'd0; A = 32'd2; B = 32'd2; start = 1'b1; end
      else start = 1'b0;
      cnt++;
      tick;
    end
    start = 1'b0;
    n_tests++;
    if (cnt != DC) begin n_fail++; $display("FAIL divz busy_cycles: got %0d want %0d", cnt, DC); end
    n_tests++;
    if ({hi, lo} !== {32'h11, 32'h22}) begin
      n_fail++; $display("FAIL divz hilo: got %h %h want 11 22", hi, lo);
    end
    tick;
    n_tests++;
    if ({busy, hi, lo} !== {1'b0, 32'h11, 32'h22}) begin
      n_fail++; $display("FAIL ignored_start: got %b %h %h want 0 11 22", busy, hi, lo);
    end
    m_hl = {32'h11, 32'h22};
  endtask

  task automatic test_back_to_back;
    run_op("b2b_multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_model("b2b_mult", 3'd0, $urandom, $urandom);
    run_model("b2b_div", 3'd2, $urandom, 32'd13);
    run_model("b2b_mthi", 3'd4, $urandom, $urandom);
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd;
    run_op("madd_mthi", 3'd4, 32'd0, 32'd0, 32'd0, m_hl[31:0]);
    run_op("madd_mtlo", 3'd5, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF);
    run_op("maddu_wrap", 3'd7, 32'd1, 32'd1, 32'd1, 32'd0);
    run_op("madd_clr_lo", 3'd5, 32'd0, 32'd0, 32'd1, 32'd0);
    run_op("madd_clr_hi", 3'd4, 32'd0, 32'd0, 32'd0, 32'd0);
    run_op("madd_neg", 3'd6, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask
`else
  task automatic test_undef_ops;
    run_op("undef6", 3'd6, $urandom, $urandom, m_hl[63:32], m_hl[31:0]);
    run_op("undef7", 3'd7, $urandom, $urandom, m_hl[63:32], m_hl[31:0]);
  endtask
`endif

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  o;
      logic [31:0] b;
      o = 3'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_model("rand", o, $urandom, b);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_mult;
    test_div;
    test_divzero_ignored;
    test_back_to_back;
`ifdef MDU_MADD_EN
    test_madd;
`else
    test_undef_ops;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
